// File: rtl/musa_dmem_arbiter.sv
// Two-port arbiter/sequencer for the MUSA single-port data memory (1-cycle read latency).
// Core (C) and external loader (E) share the RAM; each transaction runs IDLE -> ACCESS -> RESP.
module musa_dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int CORE_PRIO = 1,
  parameter int MAX_WAIT  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_stall,
  input  logic              e_req,
  input  logic              e_we,
  input  logic [ADDR_W-1:0] e_addr,
  input  logic [DATA_W-1:0] e_wdata,
  output logic              e_gnt,
  output logic              e_rvalid,
  output logic [DATA_W-1:0] e_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

  state_t              r_state, w_state_nxt;
  logic                r_owner;  // 0 = core, 1 = external; doubles as last owner for round-robin
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [3:0]          r_wait, w_wait_nxt;
  logic [DATA_W-1:0]   r_c_rdata, r_e_rdata;
  logic                w_any_req, w_e_wins, w_take, w_resp;

  always_comb begin
    w_any_req = c_req | e_req;
    w_e_wins  = e_req;
    if (c_req && e_req) begin
      if (CORE_PRIO != 0) w_e_wins = (r_wait == WAIT_LIM);
      else                w_e_wins = ~r_owner;
    end
    // Grants are gated by reset so nothing leaks out while rst_n is low
    w_take = rst_n & (r_state == S_IDLE) & w_any_req;
  end

  always_comb begin
    w_wait_nxt = r_wait;
    if (r_state == S_IDLE) begin
      if (!e_req || w_e_wins)     w_wait_nxt = 4'd0;
      else if (r_wait < WAIT_LIM) w_wait_nxt = r_wait + 4'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_any_req) w_state_nxt = S_ACCESS;
      S_ACCESS: w_state_nxt = S_RESP;
      S_RESP:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_wait  <= 4'd0;
      r_owner <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
      if (w_take) begin
        r_owner <= w_e_wins;
        r_we    <= w_e_wins ? e_we    : c_we;
        r_addr  <= w_e_wins ? e_addr  : c_addr;
        r_wdata <= w_e_wins ? e_wdata : c_wdata;
      end
    end
  end

  // Read data is live from mem_q during RESP and held afterwards until the same port reads again
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c_rdata <= '0;
      r_e_rdata <= '0;
    end else if (w_resp && !r_we) begin
      if (r_owner) r_e_rdata <= mem_q;
      else         r_c_rdata <= mem_q;
    end
  end

  assign w_resp      = (r_state == S_RESP);
  assign c_gnt       = w_take & ~w_e_wins;
  assign e_gnt       = w_take &  w_e_wins;
  assign c_rvalid    = w_resp & ~r_owner;
  assign e_rvalid    = w_resp &  r_owner;
  assign c_rdata     = (c_rvalid && !r_we) ? mem_q : r_c_rdata;
  assign e_rdata     = (e_rvalid && !r_we) ? mem_q : r_e_rdata;
  assign c_stall     = rst_n & c_req & ~c_rvalid;
  assign mem_address = r_addr;
  assign mem_data    = r_wdata;
  assign mem_wren    = (r_state == S_ACCESS) & r_we;

endmodule

// File: tb/tb_musa_dmem_arbiter.sv
// Directed bench for musa_dmem_arbiter: a priority instance on a RAM model and a
// round-robin instance whose memory returns address ^ data.
module tb_musa_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        preload;
  logic        c_req, c_we, e_req, e_we;
  logic [31:0] c_addr, c_wdata, e_addr, e_wdata;
  logic        c_gnt, c_rvalid, c_stall, e_gnt, e_rvalid, mem_wren;
  logic [31:0] c_rdata, e_rdata, mem_address, mem_data, mem_q;
  logic [31:0] mem [0:255];

  logic        rc_req, re_req;
  logic [31:0] rc_addr, re_addr;
  logic        rc_gnt, rc_rvalid, rc_stall, re_gnt, re_rvalid, r_mem_wren;
  logic [31:0] rc_rdata, re_rdata, r_mem_address, r_mem_data, r_mem_q;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  musa_dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .CORE_PRIO(1), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_stall(c_stall),
    .e_req(e_req), .e_we(e_we), .e_addr(e_addr), .e_wdata(e_wdata),
    .e_gnt(e_gnt), .e_rvalid(e_rvalid), .e_rdata(e_rdata),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
  );

  musa_dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .CORE_PRIO(0), .MAX_WAIT(4)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .c_req(rc_req), .c_we(1'b0), .c_addr(rc_addr), .c_wdata(32'd0),
    .c_gnt(rc_gnt), .c_rvalid(rc_rvalid), .c_rdata(rc_rdata), .c_stall(rc_stall),
    .e_req(re_req), .e_we(1'b0), .e_addr(re_addr), .e_wdata(32'd0),
    .e_gnt(re_gnt), .e_rvalid(re_rvalid), .e_rdata(re_rdata),
    .mem_address(r_mem_address), .mem_data(r_mem_data), .mem_wren(r_mem_wren), .mem_q(r_mem_q)
  );

  // Synchronous single-port RAM, 1-cycle read latency
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
      mem[8'h10] <= 32'hDEADBEEF;
      mem[8'h30] <= 32'h0000_0055;
    end else if (mem_wren && mem_address < 32'd256) begin
      mem[mem_address[7:0]] <= mem_data;
    end
    mem_q <= mem[mem_address[7:0]];
  end

  always @(posedge clk) r_mem_q <= r_mem_address ^ r_mem_data ^ {31'd0, r_mem_wren};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp2;

  initial begin
    rst_n = 1'b0; preload = 1'b1;
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10; c_wdata = 32'd0;
    e_req = 1'b1; e_we = 1'b0; e_addr = 32'h20; e_wdata = 32'd0;
    rc_req = 1'b0; re_req = 1'b0; rc_addr = 32'h44; re_addr = 32'h88;
    #12;
    // Reset: every output low even with requests pending
    check("rst_c_gnt", 32'(c_gnt), 32'd0);
    check("rst_e_gnt", 32'(e_gnt), 32'd0);
    check("rst_c_stall", 32'(c_stall), 32'd0);
    check("rst_rvalid", 32'({c_rvalid, e_rvalid}), 32'd0);
    check("rst_rdata", c_rdata | e_rdata, 32'd0);
    check("rst_mem_addr", mem_address, 32'd0);
    check("rst_mem_data", mem_data, 32'd0);
    check("rst_mem_wren", 32'(mem_wren), 32'd0);
    c_req = 1'b0; e_req = 1'b0;
    step(); preload = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    // Single core read of 0x10
    step(); c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10; #1;
    check("rd_c_gnt", 32'(c_gnt), 32'd1);
    check("rd_stall0", 32'(c_stall), 32'd1);
    step(); c_addr = 32'h99; #1;
    check("rd_addr", mem_address, 32'h10);
    check("rd_wren", 32'(mem_wren), 32'd0);
    check("rd_gnt1", 32'(c_gnt), 32'd0);
    check("rd_stall1", 32'(c_stall), 32'd1);
    step(); #1;
    check("rd_rvalid", 32'(c_rvalid), 32'd1);
    check("rd_rdata", c_rdata, 32'hDEADBEEF);
    check("rd_stall2", 32'(c_stall), 32'd0);
    check("rd_e_rvalid", 32'(e_rvalid), 32'd0);
    step(); c_req = 1'b0; #1;
    check("rd_rvalid_off", 32'(c_rvalid), 32'd0);
    check("rd_rdata_hold", c_rdata, 32'hDEADBEEF);

    // External write 0x1234 -> 0x20
    step(); e_req = 1'b1; e_we = 1'b1; e_addr = 32'h20; e_wdata = 32'h1234; #1;
    check("wr_e_gnt", 32'(e_gnt), 32'd1);
    check("wr_wren0", 32'(mem_wren), 32'd0);
    step(); #1;
    check("wr_wren1", 32'(mem_wren), 32'd1);
    check("wr_addr", mem_address, 32'h20);
    check("wr_data", mem_data, 32'h1234);
    check("wr_e_rvalid1", 32'(e_rvalid), 32'd0);
    step(); #1;
    check("wr_wren2", 32'(mem_wren), 32'd0);
    check("wr_e_rvalid2", 32'(e_rvalid), 32'd1);
    check("wr_e_rdata", e_rdata, 32'd0);
    step(); e_req = 1'b0; e_we = 1'b0; #1;
    check("wr_mem", mem[8'h20], 32'h1234);

    // Core reads back 0x20
    step(); c_req = 1'b1; c_addr = 32'h20; #1;
    check("rb_c_gnt", 32'(c_gnt), 32'd1);
    step(); step(); #1;
    check("rb_rvalid", 32'(c_rvalid), 32'd1);
    check("rb_rdata", c_rdata, 32'h1234);
    step(); c_req = 1'b0;

    // Contention with core priority: C,C,C,C,E repeating, 3 cycles apart
    step(); c_req = 1'b1; c_addr = 32'h10; e_req = 1'b1; e_addr = 32'h20;
    for (int k = 0; k < 30; k++) begin
      #1;
      exp2 = (k % 3 != 0) ? 2'b00 : (((k / 3) % 5 == 4) ? 2'b01 : 2'b10);
      check("prio_gnt", 32'({c_gnt, e_gnt}), 32'(exp2));
      step();
    end
    c_req = 1'b0; e_req = 1'b0; #1;
    check("prio_e_rdata", e_rdata, 32'h1234);
    check("prio_c_rdata", c_rdata, 32'hDEADBEEF);

    // Round-robin contention from reset: E,C,E,C
    step(); rc_req = 1'b1; re_req = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1;
      exp2 = (k % 3 != 0) ? 2'b00 : (((k / 3) % 2 == 0) ? 2'b01 : 2'b10);
      check("rr_gnt", 32'({rc_gnt, re_gnt}), 32'(exp2));
      if (k % 3 == 2) begin
        exp2 = ((k / 3) % 2 == 0) ? 2'b01 : 2'b10;
        check("rr_rvalid", 32'({rc_rvalid, re_rvalid}), 32'(exp2));
        check("rr_rdata", exp2[0] ? re_rdata : rc_rdata, exp2[0] ? 32'h88 : 32'h44);
        check("rr_stall", 32'(rc_stall), 32'(exp2[0]));
      end
      check("rr_wren", 32'(r_mem_wren), 32'd0);
      step();
    end
    rc_req = 1'b0; re_req = 1'b0;

    // Core request pulsed while E is in ACCESS: ignored entirely
    step(); e_req = 1'b1; e_we = 1'b0; e_addr = 32'h20; #1;
    check("wd_e_gnt", 32'(e_gnt), 32'd1);
    step(); c_req = 1'b1; c_we = 1'b1; c_addr = 32'h10; c_wdata = 32'hBAD0BAD0; #1;
    check("wd_c_gnt_access", 32'(c_gnt), 32'd0);
    step(); c_req = 1'b0; #1;
    check("wd_c_gnt_resp", 32'(c_gnt), 32'd0);
    check("wd_rvalid", 32'({c_rvalid, e_rvalid}), 32'b01);
    check("wd_e_rdata", e_rdata, 32'h1234);
    step(); e_req = 1'b0; #1;
    check("wd_idle_gnt", 32'({c_gnt, e_gnt}), 32'd0);
    step(); #1;
    check("wd_no_rvalid", 32'(c_rvalid), 32'd0);
    check("wd_no_wren", 32'(mem_wren), 32'd0);
    step(); #1;
    check("wd_mem10", mem[8'h10], 32'hDEADBEEF);
    check("wd_mem20", mem[8'h20], 32'h1234);
    c_we = 1'b0;

    // Asynchronous reset in the ACCESS cycle of a core write to 0x30
    step(); c_req = 1'b1; c_we = 1'b1; c_addr = 32'h30; c_wdata = 32'hCAFE; #1;
    check("ar_c_gnt", 32'(c_gnt), 32'd1);
    step(); #1;
    check("ar_wren_pre", 32'(mem_wren), 32'd1);
    rst_n = 1'b0; #1;
    check("ar_wren", 32'(mem_wren), 32'd0);
    check("ar_gnt", 32'({c_gnt, e_gnt}), 32'd0);
    check("ar_stall", 32'(c_stall), 32'd0);
    check("ar_rvalid", 32'({c_rvalid, e_rvalid}), 32'd0);
    check("ar_mem_addr", mem_address, 32'd0);
    check("ar_rdata", c_rdata, 32'd0);
    c_req = 1'b0; c_we = 1'b0;
    step(); step();
    check("ar_rvalid_held", 32'(c_rvalid), 32'd0);
    rst_n = 1'b1;
    check("ar_mem30", mem[8'h30], 32'h55);
    step(); c_req = 1'b1; c_addr = 32'h30; #1;
    check("ar_regrant", 32'(c_gnt), 32'd1);
    step(); step(); #1;
    check("ar_rb_rvalid", 32'(c_rvalid), 32'd1);
    check("ar_rb_rdata", c_rdata, 32'h55);
    step(); c_req = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
